rr_shift_arbiter: RTL and testbench



---
 rtl/rr_shift_arbiter.sv | 127 ++++++++++++
 tb/tb_rr_shift_arbiter.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/rr_shift_arbiter.sv
// Round-robin arbiter with rotate / priority-encode / rotate-back winner selection and registered grant.
// Optional hold-timeout preemption is built when RR_SHIFT_ARB_TIMEOUT_EN is defined.
module rr_shift_arbiter #(
  parameter int N        = 8,
  parameter int MAX_HOLD = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [N-1:0]         req,
  input  logic                 done,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] gnt_idx,
  output logic                 gnt_valid,
  output logic                 preempt
);

  localparam int IW = $clog2(N);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t         state, state_n;
  logic [N-1:0]   gnt_q, gnt_n;
  logic [IW-1:0]  idx_q, idx_n;
  logic [IW-1:0]  ptr_q, ptr_n;
  logic           pre_q, pre_n;

  logic [N-1:0]   cand, rot, low, win_oh;
  logic [IW-1:0]  win_idx;
  logic           release_c, timeout, new_grant;

  if (N < 2 || (N & (N - 1)) != 0 || MAX_HOLD < 1) begin : g_bad_params
    $error("rr_shift_arbiter: N must be a power of two >= 2 and MAX_HOLD >= 1");
  end

  // Circular barrel shifters around a lowest-set-bit priority encoder.
  always_comb begin
    cand    = req & ~gnt_q;
    rot     = '0;
    win_oh  = '0;
    win_idx = '0;
    for (int i = 0; i < N; i++) rot[i] = cand[IW'(i) + ptr_q];
    low = rot & (~rot + N'(1));
    for (int i = 0; i < N; i++) win_oh[i] = low[IW'(i) - ptr_q];
    for (int i = 0; i < N; i++) if (win_oh[i]) win_idx = IW'(i);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      gnt_q <= '0;
      idx_q <= '0;
      ptr_q <= '0;
      pre_q <= 1'b0;
    end else begin
      state <= state_n;
      gnt_q <= gnt_n;
      idx_q <= idx_n;
      ptr_q <= ptr_n;
      pre_q <= pre_n;
    end
  end

  always_comb begin
    state_n   = state;
    gnt_n     = gnt_q;
    idx_n     = idx_q;
    ptr_n     = ptr_q;
    pre_n     = 1'b0;
    new_grant = 1'b0;
    release_c = 1'b0;
    case (state)
      IDLE: begin
        if (|cand) new_grant = 1'b1;
      end
      BUSY: begin
        release_c = done | ~req[idx_q] | timeout;
        if (release_c) begin
          if (|cand) begin
            new_grant = 1'b1;
            // A forced release only counts as preemption if the owner still wanted the resource.
            pre_n     = timeout & req[idx_q];
          end else begin
            state_n = IDLE;
            gnt_n   = '0;
            idx_n   = '0;
          end
        end
      end
      default: state_n = IDLE;
    endcase
    if (new_grant) begin
      state_n = BUSY;
      gnt_n   = win_oh;
      idx_n   = win_idx;
      ptr_n   = win_idx + IW'(1);
    end
  end

  always_comb begin
    gnt       = gnt_q;
    gnt_idx   = idx_q;
    gnt_valid = (state == BUSY);
    preempt   = pre_q;
  end

`ifdef RR_SHIFT_ARB_TIMEOUT_EN
  localparam int            CW        = $clog2(MAX_HOLD + 1);
  localparam logic [CW-1:0] HOLD_LAST = CW'(MAX_HOLD - 1);

  logic [CW-1:0] hold_cnt;

  // Saturating at the trigger value lets a late-arriving requester preempt right away.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      hold_cnt <= '0;
    else if (new_grant || state_n == IDLE)
      hold_cnt <= '0;
    else if (state == BUSY && hold_cnt != HOLD_LAST)
      hold_cnt <= hold_cnt + 1'b1;
  end

  assign timeout = (state == BUSY) && (hold_cnt == HOLD_LAST) && (|cand) && !done;
`else
  assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_rr_shift_arbiter.sv
// Scoreboard bench for rr_shift_arbiter: a queue-based reference model predicts each registered output,
// a monitor process compares; honours RR_SHIFT_ARB_TIMEOUT_EN.
module tb_rr_shift_arbiter;

  localparam int N        = 4;
  localparam int IW       = 2;
  localparam int MAX_HOLD = 4;
`ifdef RR_SHIFT_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  typedef struct {
    logic [N-1:0]  gnt;
    logic [IW-1:0] idx;
    logic          valid;
    logic          pre;
  } exp_t;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [N-1:0]  req   = '0;
  logic          done  = 1'b0;
  logic [N-1:0]  gnt;
  logic [IW-1:0] gnt_idx;
  logic          gnt_valid;
  logic          preempt;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_bad    = 0;

  // Reference state: current owner (-1 when idle), priority pointer, ownership cycle count.
  int owner = -1;
  int mptr  = 0;
  int mhold = 0;

  rr_shift_arbiter #(.N(N), .MAX_HOLD(MAX_HOLD)) dut (
    .clock     (clock),
    .reset     (reset),
    .req       (req),
    .done      (done),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid),
    .preempt   (preempt)
  );

  always #5 clock = ~clock;

  task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic check_output(input exp_t e);
    check_val("gnt", gnt, e.gnt);
    check_val("gnt_idx", gnt_idx, e.idx);
    check_val("gnt_valid", gnt_valid, e.valid);
    check_val("preempt", preempt, e.pre);
  endtask

  function automatic int pick(input logic [N-1:0] c);
    for (int k = 0; k < N; k++) if (c[(mptr + k) % N]) return (mptr + k) % N;
    return -1;
  endfunction

  function automatic void take(input int w);
    owner = w;
    mptr  = (w + 1) % N;
    mhold = 0;
  endfunction

  task automatic model_step(input logic [N-1:0] r, input logic d, output exp_t e);
    logic [N-1:0] others;
    bit           to;
    bit           pre;
    pre = 1'b0;
    if (owner < 0) begin
      if (r != 0) take(pick(r));
    end else begin
      others = r & ~(N'(1) << owner);
      to = TO_EN && (mhold == MAX_HOLD - 1) && (others != 0) && !d;
      if (d || !r[owner] || to) begin
        if (others != 0) begin
          pre = to && r[owner];
          take(pick(others));
        end else begin
          owner = -1;
        end
      end else if (mhold < MAX_HOLD - 1) begin
        mhold++;
      end
    end
    e.gnt   = (owner >= 0) ? N'(1) << owner : '0;
    e.idx   = (owner >= 0) ? IW'(owner) : '0;
    e.valid = (owner >= 0);
    e.pre   = pre;
  endtask

  task automatic apply_stimulus(input logic [N-1:0] r, input logic d);
    exp_t e;
    @(negedge clock);
    req  = r;
    done = d;
    model_step(r, d, e);
    exp_q.push_back(e);
  endtask

  // Monitor: every registered output is compared just after the edge that produced it.
  initial begin
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check_output(e);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [N-1:0] rr;
    repeat (2) @(posedge clock);
    #1;
    check_val("reset_gnt", gnt, 0);
    check_val("reset_valid", gnt_valid, 0);
    check_val("reset_idx", gnt_idx, 0);
    check_val("reset_preempt", preempt, 0);
    @(negedge clock);
    reset = 1'b0;

    apply_stimulus(4'b0101, 1'b0);
    apply_stimulus(4'b0101, 1'b1);
    for (int i = 0; i < 6; i++) apply_stimulus(4'b1111, 1'b1);
    apply_stimulus(4'b0100, 1'b0);
    apply_stimulus(4'b0000, 1'b0);
    apply_stimulus(4'b0000, 1'b1);

    apply_stimulus(4'b0001, 1'b0);
    for (int i = 0; i < 20; i++) apply_stimulus(4'b0011, 1'b0);
    apply_stimulus(4'b0000, 1'b1);

    apply_stimulus(4'b0010, 1'b0);
    apply_stimulus(4'b0010, 1'b0);
    @(posedge clock);
    #3;
    reset = 1'b1;
    req   = '0;
    done  = 1'b0;
    #1;
    check_val("async_rst_gnt", gnt, 0);
    check_val("async_rst_valid", gnt_valid, 0);
    check_val("async_rst_idx", gnt_idx, 0);
    owner = -1;
    mptr  = 0;
    mhold = 0;
    @(negedge clock);
    reset = 1'b0;
    apply_stimulus(4'b1000, 1'b0);
    apply_stimulus(4'b1000, 1'b1);

    rr = '0;
    for (int i = 0; i < 400; i++) begin
      for (int b = 0; b < N; b++) if ($urandom_range(0, 3) == 0) rr[b] = ~rr[b];
      apply_stimulus(rr, $urandom_range(0, 4) == 0);
    end

    repeat (3) @(posedge clock);
    #2;
    check_val("queue_drain", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
